// File: rtl/bram_fill_if.sv
// bram_fill access and clear-control bundle.
// master drives requests and fill commands; slave returns data and status.
`timescale 1ns/1ps
interface bram_fill_if #(
   parameter int unsigned WIDTH = 32
);
   logic               i_request;
   logic               i_rw;
   logic [31:0]        i_address;
   logic [WIDTH-1:0]   i_wdata;
   logic [WIDTH/8-1:0] i_wmask;
   logic [WIDTH-1:0]   o_rdata;
   logic               o_ready;
   logic               i_clear;
   logic [31:0]        i_clear_base;
   logic [31:0]        i_clear_count;
   logic [WIDTH-1:0]   i_clear_value;
   logic               o_initialized;
   logic               o_busy;
   logic               o_done;

   modport master (
      output i_request, i_rw, i_address, i_wdata, i_wmask,
      output i_clear, i_clear_base, i_clear_count, i_clear_value,
      input  o_rdata, o_ready, o_initialized, o_busy, o_done
   );

   modport slave (
      input  i_request, i_rw, i_address, i_wdata, i_wmask,
      input  i_clear, i_clear_base, i_clear_count, i_clear_value,
      output o_rdata, o_ready, o_initialized, o_busy, o_done
   );
endinterface

// File: rtl/bram_fill.sv
// Single-port BRAM with post-reset clear and runtime range fill engine.
// Ports: i_clock, i_reset_n (async low), bus (bram_fill_if.slave).
`timescale 1ns/1ps
module bram_fill #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      SIZE        = 32'h400,
   parameter int unsigned      ADDR_LSH    = 2,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = WIDTH'(32'h0)
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   bram_fill_if.slave bus
);
   localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int unsigned NB = WIDTH / 8;
   localparam logic [31:0] SZ = 32'(SIZE);

   typedef enum logic [1:0] {INIT, IDLE, FILL} state_t;

   state_t           state_q, state_d;
   logic [31:0]      ptr_q, ptr_d;
   logic [31:0]      end_q, end_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             init_q, init_d;
   logic [WIDTH-1:0] rdata_q;

   logic [WIDTH-1:0] mem [SIZE];

   logic [31:0]      acc_idx;
   logic             acc_ok;
   logic [32:0]      sum;
   logic [31:0]      clip;
   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic [NB-1:0]    wr_be;
   logic             rd_en;
   logic [AW-1:0]    rd_idx;

   assign acc_idx = bus.i_address >> ADDR_LSH;
   assign acc_ok  = acc_idx < SZ;
   assign rd_idx  = AW'(acc_idx);

   // 33-bit sum so base+count cannot wrap before clipping to SIZE
   assign sum  = {1'b0, bus.i_clear_base} + {1'b0, bus.i_clear_count};
   assign clip = (sum > {1'b0, SZ}) ? SZ : sum[31:0];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      end_d   = end_q;
      val_d   = val_q;
      ready_d = 1'b0;
      done_d  = 1'b0;
      init_d  = init_q;
      wr_en   = 1'b0;
      wr_idx  = AW'(ptr_q);
      wr_data = val_q;
      wr_be   = '1;
      rd_en   = 1'b0;
      unique case (state_q)
         INIT: begin
            wr_en   = 1'b1;
            wr_data = CLEAR_VALUE;
            ptr_d   = ptr_q + 32'd1;
            if (ptr_q == SZ - 32'd1) begin
               state_d = IDLE;
               init_d  = 1'b1;
               ptr_d   = '0;
            end
         end
         IDLE: begin
            ready_d = bus.i_request;
            if (bus.i_request) begin
               if (bus.i_rw) begin
                  wr_en   = acc_ok;
                  wr_idx  = AW'(acc_idx);
                  wr_data = bus.i_wdata;
                  wr_be   = bus.i_wmask;
               end else begin
                  rd_en = 1'b1;
               end
            end
            if (bus.i_clear) begin
               val_d = bus.i_clear_value;
               if (bus.i_clear_count == '0 ||
                   bus.i_clear_base >= SZ) begin
                  done_d = 1'b1;
               end else begin
                  ptr_d   = bus.i_clear_base;
                  end_d   = clip;
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 32'd1;
            if (ptr_q == end_q - 32'd1) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = INIT;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= INIT;
         ptr_q   <= '0;
         end_q   <= '0;
         val_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         end_q   <= end_d;
         val_q   <= val_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         init_q  <= init_d;
      end
   end

   // Array has no reset so it maps onto block RAM byte enables
   always_ff @(posedge i_clock) begin
      for (int k = 0; k < NB; k++) begin
         if (wr_en && wr_be[k]) begin
            mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= acc_ok ? mem[rd_idx] : '0;
      end
   end

   assign bus.o_rdata       = rdata_q;
   assign bus.o_ready       = ready_q;
   assign bus.o_initialized = init_q;
   assign bus.o_busy        = (state_q != IDLE);
   assign bus.o_done        = done_q;
endmodule

// File: doc/bram_fill.md
Name: bram_fill

Overview:
- Parametrised single-port block RAM with a built-in clear engine. It is the successor to the fixed power-on-clear BRAM wrapper.
- After reset it clears the whole array to CLEAR_VALUE. It adds three things the older wrapper lacks:
  - runtime-triggered fill of an address range with a caller-supplied value;
  - byte-masked writes;
  - explicit busy and done status.
- Used for framebuffers, tag RAMs and scratch memories that software must wipe without a CPU loop.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- SIZE, 32'h400, depth in words.
- ADDR_LSH, 2, right shift from byte address to word index.
- CLEAR_VALUE, 32'h0, word written during post-reset clear; truncated to WIDTH.

Ports:
- i_clock  in  1  clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_request  in  1  access request, sampled every edge.
- i_rw  in  1  0=read, 1=write.
- i_address  in  32  byte address.
- i_wdata  in  WIDTH  write data.
- i_wmask  in  WIDTH/8  byte write enables; bit k covers bits [8k+7:8k].
- o_rdata  out  WIDTH  read data.
- o_ready  out  1  access completed.
- i_clear  in  1  start runtime fill (single-cycle pulse).
- i_clear_base  in  32  first word index to fill.
- i_clear_count  in  32  number of words to fill.
- i_clear_value  in  WIDTH  fill word.
- o_initialized  out  1  post-reset clear complete.
- o_busy  out  1  clear engine active; accesses stalled.
- o_done  out  1  one-cycle pulse when a runtime fill finishes.

Behaviour:
- Reset (i_reset_n low, asynchronous): state=INIT, clear pointer=0.
  - Output values: o_rdata=0, o_ready=0, o_initialized=0, o_busy=1, o_done=0.
  - Array contents are not reset.
- State INIT:
  - The first edge after i_reset_n rises writes CLEAR_VALUE at index 0.
  - Each following edge writes the next index, through SIZE-1.
  - The edge writing SIZE-1 moves to IDLE.
  - o_initialized rises in the same cycle o_busy falls, SIZE cycles after reset release, and stays high until the next reset.
  - i_request and i_clear are ignored in INIT.
- State IDLE: each edge with i_request=1 performs one access.
  - Read: o_rdata <= mem[i_address>>ADDR_LSH].
  - Write: update only the bytes whose i_wmask bit is 1; bytes with mask 0 keep their value.
  - o_ready <= i_request, registered, so read data is valid in the cycle o_ready=1. Latency is 1 cycle.
  - Back-to-back accesses are allowed every cycle.
  - Out-of-range word index (>=SIZE): write dropped, read returns 0, o_ready still pulses.
  - o_rdata holds its last value when no read occurs.
- Fill trigger, in IDLE at an edge with i_clear=1:
  - latch base, value and end = min(base+count, SIZE), computed without 32-bit overflow;
  - if count=0 or base>=SIZE: no fill, stay IDLE, pulse o_done next cycle;
  - otherwise go to FILL; o_busy=1 from the next cycle.
- i_clear and i_request in the same IDLE edge: the access is performed and o_ready pulses next cycle; the fill starts on the following edge. The access therefore sees pre-fill contents.
- State FILL:
  - Each edge writes the latched value to the pointer index and increments the pointer.
  - The edge writing end-1 returns to IDLE; o_busy=0 and o_done=1 for exactly one cycle after that edge.
  - A fill of n words occupies n cycles of o_busy.
- i_request during FILL is not accepted and o_ready stays 0. The requester must hold the request, which is serviced on the first IDLE edge.
- i_clear during FILL or INIT is ignored; no queueing.
- Reset mid-FILL aborts the fill, returns to INIT, repeats the full CLEAR_VALUE clear, and gives no o_done.
- Pointer and end registers are 32 bits; no wrap-around past SIZE.
- Array is inferred as block RAM with one write port and one read port.

Test Plan:
- Post-reset clear (SIZE=16, CLEAR_VALUE=0xA5A5A5A5):
  - release reset -> o_busy=1 for 16 cycles, o_initialized rises at cycle 16;
  - reads of words 0..15 -> 0xA5A5A5A5 with o_ready one cycle after each request.
- Byte mask: write 0x11223344 mask 4'b1111 to byte address 0x8, then 0xFFFFFFFF mask 4'b0101 -> read 0x8 returns 0x11FF33FF.
- Runtime fill: i_clear base=4 count=3 value=0xDEADBEEF -> o_busy high 3 cycles, o_done single pulse; words 3 and 7 unchanged, words 4..6 read 0xDEADBEEF.
- Clipping and zero count:
  - base=14 count=10 -> only words 14,15 filled, o_busy 2 cycles;
  - count=0 -> no o_busy, o_done pulses next cycle.
- Stall: read held during an active fill -> o_ready=0 while o_busy=1; first IDLE cycle services the read and returns the filled value.
- Reset mid-fill: assert i_reset_n low during FILL -> outputs go to reset values immediately; full 16-cycle INIT follows; no o_done; all words read CLEAR_VALUE.
